// File: rtl/argmax_13_32_if.sv
// Handshake bundle between the 13x32 fully connected layer, the argmax stage
// and the downstream result consumer.
//
// Signals:
//   input_valid / input_ready  element handshake (producer -> argmax)
//   input_data                 signed element, delivered in index order
//   output_valid / output_ready result handshake (argmax -> consumer)
//   output_data                signed maximum of the vector
//   output_index               index of that maximum
//
// Modports:
//   slave  - the argmax stage itself
//   master - the environment driving elements and consuming results
interface argmax_13_32_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
);
  logic                     input_valid;
  logic                     input_ready;
  logic signed [DATA_W-1:0] input_data;
  logic                     output_valid;
  logic                     output_ready;
  logic signed [DATA_W-1:0] output_data;
  logic [IDX_W-1:0]         output_index;

  modport slave (
    input  input_valid, input_data, output_ready,
    output input_ready, output_valid, output_data, output_index
  );

  modport master (
    output input_valid, input_data, output_ready,
    input  input_ready, output_valid, output_data, output_index
  );
endinterface

// File: rtl/argmax_13_32.sv
// Streaming argmax over 13-element vectors of signed 32-bit values.
// Consumes one element per input handshake and, after the 13th element,
// presents the maximum value and its index (lowest index wins on ties).
// The result sits in its own register, so the following vector can
// accumulate while the previous result waits for the consumer; only the
// last element of that next vector is stalled until the result drains.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    argmax_13_32_if.slave handshake bundle (see interface header)
module argmax_13_32 #(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  argmax_13_32_if.slave  bus
);
  localparam int M    = 13;
  localparam int LOGM = $clog2(M);
  localparam logic [LOGM-1:0] LAST_IDX = LOGM'(M - 1);

  // Running state for the vector currently streaming in
  logic [LOGM-1:0]          r_cnt;
  logic signed [DATA_W-1:0] r_cur_max;
  logic [LOGM-1:0]          r_cur_idx;

  // Result register, independent from the running state
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic [LOGM-1:0]          r_out_idx;

  logic                     w_first;
  logic                     w_last;
  logic                     w_in_ready;
  logic                     w_in_acc;
  logic                     w_out_acc;
  logic                     w_take;
  logic signed [DATA_W-1:0] w_in_data;
  logic signed [DATA_W-1:0] w_nxt_max;
  logic [LOGM-1:0]          w_nxt_idx;

  function automatic logic is_greater(input logic signed [DATA_W-1:0] a,
                                      input logic signed [DATA_W-1:0] b);
    return a > b;
  endfunction

  assign w_in_data = bus.input_data;
  assign w_first   = (r_cnt == '0);
  assign w_last    = (r_cnt == LAST_IDX);

  // Only the last element has to wait: it is the one that overwrites the
  // result register. Combinational from output_ready so a draining result
  // and a new last element can both handshake in the same cycle.
  assign w_in_ready = !(w_last && r_out_valid && !bus.output_ready);
  assign w_in_acc   = bus.input_valid && w_in_ready;
  assign w_out_acc  = r_out_valid && bus.output_ready;

  // Strict compare keeps the earliest index on ties; element 0 always loads.
  assign w_take    = w_first || is_greater(w_in_data, r_cur_max);
  assign w_nxt_max = w_take ? w_in_data : r_cur_max;
  assign w_nxt_idx = w_first ? '0 : (w_take ? r_cnt : r_cur_idx);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_cur_max <= '0;
      r_cur_idx <= '0;
    end else if (w_in_acc) begin
      r_cnt     <= w_last ? '0 : r_cnt + LOGM'(1);
      r_cur_max <= w_nxt_max;
      r_cur_idx <= w_nxt_idx;
    end
  end

  // A new result wins over a simultaneous drain, keeping output_valid high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
    end else if (w_in_acc && w_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_nxt_max;
      r_out_idx   <= w_nxt_idx;
    end else if (w_out_acc) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.input_ready  = w_in_ready;
  assign bus.output_valid = r_out_valid;
  assign bus.output_data  = r_out_data;
  assign bus.output_index = r_out_idx;
endmodule

// File: tb/tb_argmax_13_32.sv
module tb_argmax_13_32;
  typedef logic signed [31:0] vec_t [13];
  typedef struct {
    logic signed [31:0] d;
    logic [3:0]         i;
    int                 c;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   valid_cnt = 0;
  res_t res_q[$];
  res_t mon_r;

  argmax_13_32_if bus();

  argmax_13_32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Result monitor: samples 1 time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (reset) begin
      if (bus.output_valid) valid_cnt++;
      if (bus.output_valid && bus.output_ready) begin
        mon_r.d = bus.output_data;
        mon_r.i = bus.output_index;
        mon_r.c = cyc;
        res_q.push_back(mon_r);
      end
    end
  end

  // Reference: first position holding the largest signed value.
  function automatic void ref_argmax(input vec_t v, output logic signed [31:0] d,
                                     output logic [3:0] idx);
    int best;
    best = 0;
    for (int k = 1; k < 13; k++)
      if (v[k] > v[best]) best = k;
    d   = v[best];
    idx = 4'(best);
  endfunction

  task automatic send_elem(input logic signed [31:0] d, input int max_bub,
                           output int acc_cyc);
    int  n;
    bit  ok;
    n = (max_bub > 0) ? int'($urandom_range(max_bub, 0)) : 0;
    repeat (n) begin
      @(negedge clk);
      bus.input_valid = 1'b0;
    end
    @(negedge clk);
    bus.input_valid = 1'b1;
    bus.input_data  = d;
    ok = 1'b0;
    acc_cyc = -1;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (t > 0) @(negedge clk);
      #4;
      if (bus.input_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: input_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic send_vec(input vec_t v, input int max_bub, output int last_cyc);
    for (int k = 0; k < 13; k++) send_elem(v[k], max_bub, last_cyc);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.input_valid = 1'b0;
  endtask

  task automatic wait_result(output res_t r);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      if (res_q.size() > 0) got = 1'b1;
      else begin
        @(negedge clk);
        #6;
      end
    end
    if (got) r = res_q.pop_front();
    else begin
      total++; bad++;
      $display("FAIL result_timeout: no result within 40 cycles");
      r.d = 'x; r.i = 'x; r.c = -1;
    end
  endtask

  function automatic vec_t ascending();
    vec_t v;
    for (int k = 0; k < 13; k++) v[k] = 32'(10 * k);
    return v;
  endfunction

  task automatic check_res(input string name, input res_t r,
                           input logic signed [31:0] ed, input logic [3:0] ei);
    total++;
    if (r.d !== ed || r.i !== ei) begin
      bad++;
      $display("FAIL %s: got data=%0d index=%0d, required data=%0d index=%0d",
               name, r.d, r.i, ed, ei);
    end
  endtask

  task automatic test_reset();
    bus.input_valid  = 1'b0;
    bus.input_data   = '0;
    bus.output_ready = 1'b1;
    reset = 1'b0;
    #12;
    total++;
    if (bus.output_valid !== 1'b0 || bus.output_data !== 32'sd0 ||
        bus.output_index !== 4'd0 || bus.input_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: ov=%b od=%0d oi=%0d ir=%b, required 0 0 0 1",
               bus.output_valid, bus.output_data, bus.output_index, bus.input_ready);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ascending();
    res_t r;
    int   lc;
    logic signed [31:0] ed;
    logic [3:0] ei;
    bus.output_ready = 1'b1;
    res_q.delete();
    valid_cnt = 0;
    send_vec(ascending(), 0, lc);
    idle();
    ref_argmax(ascending(), ed, ei);
    wait_result(r);
    check_res("ascending", r, ed, ei);
    total++;
    if (r.c !== lc + 1) begin
      bad++;
      $display("FAIL ascending_latency: result cycle=%0d, required %0d", r.c, lc + 1);
    end
    repeat (4) @(negedge clk);
    total++;
    if (valid_cnt !== 1) begin
      bad++;
      $display("FAIL ascending_valid_width: valid cycles=%0d, required 1", valid_cnt);
    end
  endtask

  task automatic run_vec(input string name, input vec_t v, input int max_bub);
    res_t r;
    int   lc;
    logic signed [31:0] ed;
    logic [3:0] ei;
    res_q.delete();
    send_vec(v, max_bub, lc);
    idle();
    ref_argmax(v, ed, ei);
    wait_result(r);
    check_res(name, r, ed, ei);
  endtask

  task automatic test_ties_negatives();
    vec_t v;
    bus.output_ready = 1'b1;
    for (int k = 0; k < 13; k++) v[k] = -32'sd5;
    run_vec("ties_all_minus5", v, 0);
    total++;
    if (bus.output_index !== 4'd0 && bus.output_valid) bad++;
    for (int k = 0; k < 13; k++) v[k] = 32'sd0;
    v[3] = 32'sd1000;
    v[9] = 32'sd1000;
    run_vec("ties_1000_at_3_9", v, 0);
  endtask

  task automatic test_signed_extremes();
    vec_t v;
    bus.output_ready = 1'b1;
    for (int k = 0; k < 13; k++) v[k] = 32'sh8000_0000;
    v[7] = 32'sh8000_0001;
    run_vec("extreme_min_plus1", v, 0);
    for (int k = 0; k < 13; k++) v[k] = 32'sh8000_0000;
    v[0] = 32'shFFFF_FFFF;
    run_vec("extreme_minus1_first", v, 0);
  endtask

  task automatic test_back_to_back();
    vec_t a, b;
    res_t r1, r2;
    int   lc;
    bus.output_ready = 1'b1;
    res_q.delete();
    a = ascending();
    for (int k = 0; k < 13; k++) b[k] = 32'(100 - k);
    send_vec(a, 0, lc);
    send_vec(b, 0, lc);
    idle();
    wait_result(r1);
    wait_result(r2);
    check_res("b2b_first", r1, 32'sd120, 4'd12);
    check_res("b2b_second", r2, 32'sd100, 4'd0);
    total++;
    if (r2.c - r1.c !== 13) begin
      bad++;
      $display("FAIL b2b_spacing: result gap=%0d cycles, required 13", r2.c - r1.c);
    end
  endtask

  task automatic test_backpressure();
    vec_t v1, v2;
    int   lc;
    bit   stable;
    bus.output_ready = 1'b0;
    for (int k = 0; k < 13; k++) v1[k] = 32'(k);
    v1[2] = 32'sd50;
    for (int k = 0; k < 13; k++) v2[k] = -32'(k);
    v2[11] = 32'sd77;
    send_vec(v1, 0, lc);
    for (int k = 0; k < 12; k++) send_elem(v2[k], 0, lc);
    @(negedge clk);
    bus.input_valid = 1'b1;
    bus.input_data  = v2[12];
    stable = 1'b1;
    for (int t = 0; t < 3; t++) begin
      if (t > 0) @(negedge clk);
      #4;
      if (bus.output_valid !== 1'b1 || bus.output_data !== 32'sd50 ||
          bus.output_index !== 4'd2) stable = 1'b0;
      total++;
      if (bus.input_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_input_stall: input_ready=%b, required 0", bus.input_ready);
      end
    end
    total++;
    if (!stable) begin
      bad++;
      $display("FAIL bp_hold: ov=%b data=%0d idx=%0d, required 1 50 2",
               bus.output_valid, bus.output_data, bus.output_index);
    end
    @(negedge clk);
    bus.output_ready = 1'b1;
    #4;
    total++;
    if (bus.input_ready !== 1'b1 || bus.output_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_dual_handshake: ir=%b ov=%b, required 1 1",
               bus.input_ready, bus.output_valid);
    end
    @(negedge clk);
    bus.input_valid = 1'b0;
    #4;
    total++;
    if (bus.output_valid !== 1'b1 || bus.output_data !== 32'sd77 ||
        bus.output_index !== 4'd11) begin
      bad++;
      $display("FAIL bp_second_result: ov=%b data=%0d idx=%0d, required 1 77 11",
               bus.output_valid, bus.output_data, bus.output_index);
    end
    @(negedge clk);
    #4;
    total++;
    if (bus.output_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: output_valid=%b, required 0", bus.output_valid);
    end
    res_q.delete();
  endtask

  task automatic test_bubbles();
    bus.output_ready = 1'b1;
    run_vec("bubbles_ascending", ascending(), 3);
  endtask

  task automatic test_reset_mid();
    vec_t v;
    res_t r;
    int   lc;
    bus.output_ready = 1'b0;
    for (int k = 0; k < 13; k++) v[k] = 32'sd7;
    send_vec(v, 0, lc);
    for (int k = 0; k < 6; k++) send_elem(32'sd1000, 0, lc);
    @(negedge clk);
    bus.input_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (bus.output_valid !== 1'b0 || bus.output_data !== 32'sd0 ||
        bus.output_index !== 4'd0 || bus.input_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_state: ov=%b od=%0d oi=%0d ir=%b, required 0 0 0 1",
               bus.output_valid, bus.output_data, bus.output_index, bus.input_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.output_ready = 1'b1;
    res_q.delete();
    send_vec(ascending(), 0, lc);
    idle();
    wait_result(r);
    check_res("reset_mid_after", r, 32'sd120, 4'd12);
  endtask

  task automatic test_random();
    localparam int N = 20;
    vec_t v;
    res_t r;
    int   lc;
    bit   rdone;
    logic signed [31:0] ed [N];
    logic [3:0]         ei [N];
    logic signed [31:0] picks [5];
    picks = '{32'sh8000_0000, 32'sh7FFF_FFFF, -32'sd1, 32'sd0, 32'sd1};
    res_q.delete();
    rdone = 1'b0;
    fork
      begin
        for (int n = 0; n < N; n++) begin
          for (int k = 0; k < 13; k++)
            v[k] = ($urandom_range(2, 0) == 0) ? picks[$urandom_range(4, 0)]
                                               : 32'($urandom);
          ref_argmax(v, ed[n], ei[n]);
          send_vec(v, (n % 2) * 2, lc);
        end
        idle();
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(negedge clk);
          bus.output_ready = ($urandom_range(3, 0) != 0);
        end
        bus.output_ready = 1'b1;
      end
    join
    for (int n = 0; n < N; n++) begin
      wait_result(r);
      check_res($sformatf("random_vec%0d", n), r, ed[n], ei[n]);
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_ties_negatives();
    test_signed_extremes();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
